// File: rtl/pwm_duty_meter.sv
// PWM duty-cycle meter: measures high time and period between rising edges and reports duty as 0..100 %.
// Optional build macro PWM_DUTY_ROUND_EN selects round-to-nearest instead of truncation.
module pwm_duty_meter #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [6:0]       duty_pct,
    output logic             duty_valid,
    output logic [CNT_W-1:0] period_cnt,
    output logic             stuck,
    output logic             overrun
);
    // Result interface: duty_valid is a single-cycle strobe with no back-pressure;
    // duty_pct/period_cnt are valid in that cycle and hold until the next strobe.

    localparam int NB = CNT_W + 7;
    localparam int IW = $clog2(NB + 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        MEASURE    = 2'd1,
        TIMEOUT_ST = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic s1, s, s_d;
    logic rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1  <= 1'b0;
            s   <= 1'b0;
            s_d <= 1'b0;
        end else begin
            s1  <= pwm_in;
            s   <= s1;
            s_d <= s;
        end
    end

    assign rise = s & ~s_d;

    logic [CNT_W-1:0] hi_cnt, per_cnt;
    logic             timeout_hit;
    logic             capture;

    assign timeout_hit = (per_cnt == CNT_W'(TIMEOUT));
    assign capture     = (state_q == MEASURE) && rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (rise) state_d = MEASURE;
            MEASURE:    if (!rise && timeout_hit) state_d = TIMEOUT_ST;
            TIMEOUT_ST: state_d = rise ? MEASURE : IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Every rise restarts the window; the rise that counts is already high for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_cnt  <= '0;
            per_cnt <= '0;
        end else if (rise) begin
            hi_cnt  <= CNT_W'(1);
            per_cnt <= CNT_W'(1);
        end else if (state_q == MEASURE) begin
            per_cnt <= per_cnt + CNT_W'(1);
            if (s) hi_cnt <= hi_cnt + CNT_W'(1);
        end else begin
            hi_cnt  <= '0;
            per_cnt <= '0;
        end
    end

    logic [NB-1:0] num_w;

    always_comb begin
`ifdef PWM_DUTY_ROUND_EN
        num_w = {7'd0, hi_cnt} * NB'(100) + {8'd0, per_cnt[CNT_W-1:1]};
`else
        num_w = {7'd0, hi_cnt} * NB'(100);
`endif
    end

    logic             div_busy;
    logic [IW-1:0]    div_iter;
    logic [NB-1:0]    div_q;
    logic [CNT_W-1:0] div_r;
    logic [CNT_W-1:0] div_den;
    logic             div_done;
    logic             div_free;
    logic [CNT_W:0]   trial;
    logic             trial_ge;
    logic [CNT_W-1:0] r_next;

    assign div_done = div_busy && (div_iter == IW'(NB));
    // A capture landing on the completion cycle is accepted: the result leaves as the new operands load.
    assign div_free = !div_busy || div_done;

    // Restoring step: remainder stays below the divisor, so CNT_W bits hold it between steps.
    assign trial    = {div_r, div_q[NB-1]};
    assign trial_ge = (trial >= {1'b0, div_den});
    assign r_next   = trial_ge ? CNT_W'(trial - {1'b0, div_den}) : trial[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            div_busy <= 1'b0;
            div_iter <= '0;
            div_q    <= '0;
            div_r    <= '0;
            div_den  <= '0;
        end else if (capture && div_free) begin
            div_busy <= 1'b1;
            div_iter <= '0;
            div_q    <= num_w;
            div_r    <= '0;
            div_den  <= per_cnt;
        end else if (div_done) begin
            div_busy <= 1'b0;
        end else if (div_busy) begin
            div_q    <= {div_q[NB-2:0], trial_ge};
            div_r    <= r_next;
            div_iter <= div_iter + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_pct   <= '0;
            period_cnt <= '0;
            duty_valid <= 1'b0;
            stuck      <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            overrun    <= 1'b0;
            if (state_q == MEASURE && !rise && timeout_hit) begin
                duty_pct   <= s ? 7'd100 : 7'd0;
                period_cnt <= '0;
                duty_valid <= 1'b1;
                stuck      <= 1'b1;
            end else if (div_done) begin
                duty_pct   <= div_q[6:0];
                period_cnt <= div_den;
                duty_valid <= 1'b1;
            end
            if (rise) stuck <= 1'b0;
            if (capture && !div_free) overrun <= 1'b1;
        end
    end

endmodule

// File: doc/pwm_duty_meter.md
Name: pwm_duty_meter

Overview:
- Receive-side counterpart of the light-brightness PWM generator.
- Samples a PWM waveform and measures its high time and period in clk cycles, rising edge to rising edge.
- Reports duty cycle as an integer percentage 0..100 on a 7-bit bus, the same encoding as the generator's duty-cycle input.
- Used for loopback checking of the brightness path and for reading externally supplied PWM dimming signals.

Parameters:
- CNT_W, 16: width of the high-time and period counters, in bits.
- TIMEOUT, 50000: clk cycles without a rising edge before the input is declared static. Must be ≤ 2^CNT_W−1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pwm_in  in  1  asynchronous PWM input.
- duty_pct  out  7  last measured duty cycle, percent, 0..100.
- duty_valid  out  1  one-cycle pulse when duty_pct updates.
- period_cnt  out  CNT_W  last measured period in clk cycles.
- stuck  out  1  high while the input is static (timeout).
- overrun  out  1  one-cycle pulse when a measurement is dropped.

Behaviour:
- Input conditioning:
  - pwm_in passes through a 2-FF synchronizer, then a delay FF.
  - rise = s & ~s_d; fall = ~s & s_d.
  - "Cycle E" is the clk edge at which rise is first seen.
- Reset: every output is 0, all counters are 0, FSM is in IDLE.
- FSM:
  - IDLE: counters held at 0. On rise → MEASURE with hi_cnt=1, per_cnt=1.
  - MEASURE:
    - per_cnt increments every cycle.
    - hi_cnt increments while s=1.
    - On rise: capture num = hi_cnt*100 (CNT_W+7 bits) and den = per_cnt into the divider, start the divider, and restart hi_cnt=1, per_cnt=1. Stay in MEASURE; measurement and division overlap.
    - On per_cnt reaching TIMEOUT → TIMEOUT_ST.
  - TIMEOUT_ST (one cycle):
    - duty_pct = 100 if s=1, else 0.
    - period_cnt = 0, duty_valid pulses, stuck = 1.
    - → IDLE.
    - stuck clears at the next rise.
- Divider:
  - Restoring, one quotient bit per cycle, CNT_W+7 iterations.
  - Quotient is truncated toward zero.
  - hi_cnt ≤ per_cnt always holds, so the quotient is ≤ 100 and no clamp is needed.
  - duty_pct and period_cnt update, and duty_valid pulses, at cycle E + CNT_W + 8.
  - duty_pct and period_cnt hold between updates.
- Overrun:
  - If rise arrives while the divider is busy (period < CNT_W+8 cycles), the new capture is discarded and overrun pulses for 1 cycle.
  - The division in progress completes normally.
  - The counters still restart.
- First edge:
  - The rise that leaves IDLE produces no result.
  - The first duty_valid follows the second rise.
- Boundaries:
  - 0% or 100% input never has a rise and resolves only through timeout.
  - A period of 1 cycle cannot be synchronized.
  - A rise and a timeout on the same cycle: rise wins, the measurement is captured, and there is no timeout.
- Reset mid-operation: the division is aborted, no duty_valid is issued, outputs return to 0, and the FSM returns to IDLE.

Optional Feature:
- Macro: PWM_DUTY_ROUND_EN.
- Defined: the divider numerator is hi_cnt*100 + (per_cnt>>1), giving round-to-nearest. The result is still ≤ 100, because hi_cnt*100 + per_cnt/2 < (100.5)·per_cnt.
- Undefined: truncation. Latency is identical in both builds.

Test Plan:
- Reset with pwm_in toggling at period 100, high 25 → all outputs 0 while rst=1, and no duty_valid.
- pwm_in period 100 clks, high 25 → duty_valid at E+24 of the second rise, duty_pct=25, period_cnt=100. Repeat with high 50, 75, 99 → 50, 75, 99.
- Period 300, high 100 → 33 when truncating; 33 with ROUND_EN. Period 200, high 133 → 66 when truncating; 67 with ROUND_EN.
- pwm_in held high after a valid measurement for TIMEOUT cycles → duty_valid with duty_pct=100, period_cnt=0, stuck=1. Held low → duty_pct=0. stuck clears on the next rise.
- Period 10 (less than 24) → the first capture divides, the next rise while busy pulses overrun, and duty_pct reflects only non-dropped periods.
- Assert rst 5 cycles after a capture, deassert, then resume period 100 / high 50 → no stale duty_valid, and the first new duty_pct=50 follows the second rise after reset.
